odd_counter_checker: RTL and testbench
======================================

Name: odd_counter_checker

Overview:
- On-line response checker that sits at the observing end of the odd up/down counter's output bus {p3,p2,p1}.
- Samples the direction input x and the counter outputs each clock, predicts the next legal odd value (1,3,5,7 with wrap), and flags mismatches.
- Accumulates an error count and an 8-bit MISR signature for DFT readout; a FAIL state latches when the error budget is exhausted.

Parameters:
- ERR_W, 8, width of err_count (saturating).
- MAX_ERR, 4, error count at which the FSM enters FAIL; legal range 1..2^ERR_W-1.
- SYNC_LEN, 2, consecutive correct transitions required in SYNC before entering LOCK; legal range 1..7.

Ports:
- clk  in  1  rising-edge clock shared with the counter.
- rst  in  1  synchronous active-high reset.
- en  in  1  checker enable.
- x  in  1  counter direction as driven to the counter: 0 = up, 1 = down.
- p1  in  1  counter output bit 0 (LSB).
- p2  in  1  counter output bit 1.
- p3  in  1  counter output bit 2 (MSB).
- locked  out  1  high while in LOCK.
- err_pulse  out  1  one-cycle pulse per detected mismatch in LOCK.
- err_count  out  ERR_W  saturating mismatch count.
- fail  out  1  sticky; high in FAIL.
- signature  out  8  MISR contents.
- state  out  2  encoded FSM state: SYNC=0, LOCK=1, FAIL=2.

Behaviour:
- Sampling: v = {p3,p2,p1}. At each enabled edge, register v_q <= v, x_q <= x, and hist_vld <= 1.
- Prediction: exp = next(v_q, x_q). Up: 1->3->5->7->1. Down: 7->5->3->1->7.
- If v_q is even, no prediction exists and the comparison counts as a mismatch.
- The comparison of v against exp is valid only when hist_vld=1 and en=1 in the same cycle.
- Reset (rst=1 at an edge): state=SYNC, locked=0, err_pulse=0, err_count=0, fail=0, signature=8'h00, hist_vld=0, sync_cnt=0. This applies identically when reset is asserted mid-operation. The first compare happens at the 2nd enabled edge after reset.
- en=0: all registers hold, except hist_vld <= 0 and err_pulse <= 0. On en returning to 1 the FSM stays in its current state, and no compare occurs until history is rebuilt (one edge).
- SYNC:
  - Correct compare: sync_cnt++. When sync_cnt reaches SYNC_LEN, go to LOCK and clear sync_cnt.
  - Mismatch: sync_cnt=0.
  - No errors are counted and no err_pulse is raised in SYNC.
- LOCK:
  - Mismatch: err_pulse=1 for the next cycle, and err_count increments, saturating at all ones.
  - If the incremented count is >= MAX_ERR, go to FAIL in the same edge.
  - A mismatch does not drop lock.
- FAIL: absorbing until rst. fail=1, locked=0, err_pulse=0, err_count and signature frozen.
- MISR:
  - Updates only in LOCK with en=1 (including the cycle that transitions to FAIL).
  - Next value: sig <= {sig[6:0],fb} ^ {5'b0,v}, with fb = sig[7]^sig[5]^sig[4]^sig[3] (polynomial x^8+x^6+x^5+x^4+1).
  - The MISR seeds from 00 on LOCK entry: it is cleared whenever state=SYNC.
- Outputs are all registered; err_pulse and locked have 1-cycle latency from the deciding edge.
- Simultaneous events: rst dominates en. A mismatch on the edge that would complete SYNC resets sync_cnt; it does not lock.

Decomposition:
- Shared package odd_cnt_pkg:
  - State encoding constants ST_SYNC / ST_LOCK / ST_FAIL.
  - MISR polynomial tap constant 8'hB8.
  - Function next_odd(v, dir) returning the 3-bit expected value, with 3'b000 meaning illegal input.
  - The counter and any future generator reuse next_odd.
- One sub-module: odd_misr8, an 8-bit MISR with clk, rst, clr, en, din[2:0], sig[7:0].

Test Plan:
- Reset then en=1, x=0, v sequence 1,3,5,7,1,3 -> locked=1 after the 3rd edge (SYNC_LEN=2), err_count=0, fail=0, err_pulse never high.
- Locked up-count, x switched to 1 while v=5; next v=3 -> no error; then 1,7,5 -> no error; wrap 1->7 accepted.
- Locked, inject v=4 (even), then 6 -> err_pulse high two cycles, err_count=2, state stays LOCK.
- Locked, inject 4 wrong values with MAX_ERR=4 -> after the 4th, state=FAIL, fail=1, locked=0; further wrong values leave err_count=4 and signature frozen.
- Lock on 1,3,5, then feed 7,1,3 -> signature matches the reference MISR model; drop en for 3 cycles with garbage v -> signature, err_count unchanged, no err_pulse.
- Assert rst mid-LOCK with err_count=2 -> next cycle all outputs at reset values, state=SYNC, and re-lock requires SYNC_LEN+1 enabled edges.

Source files
------------

// File: rtl/odd_counter_checker_pkg.sv
// Shared definitions for the odd up/down counter family: state encoding,
// MISR taps and the legal next-value predictor.
package odd_cnt_pkg;

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_LOCK = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  typedef enum logic [1:0] {
    S_SYNC = ST_SYNC,
    S_LOCK = ST_LOCK,
    S_FAIL = ST_FAIL
  } state_t;

  // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
  localparam logic [7:0] MISR_TAPS = 8'hB8;

  // Returns 3'b000 for an even (illegal) input; 3-bit arithmetic gives the wrap.
  function automatic logic [2:0] next_odd(input logic [2:0] v, input logic dir);
    if (!v[0]) return 3'b000;
    return dir ? (v - 3'd2) : (v + 3'd2);
  endfunction

endpackage

// File: rtl/odd_counter_checker_misr8.sv
// 8-bit multiple-input signature register folding a 3-bit word per update.
module odd_misr8
  import odd_cnt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [2:0] din,
  output logic [7:0] sig
);

  logic [7:0] sig_reg;
  logic [7:0] sig_next;
  logic       fb;

  assign fb = ^(sig_reg & MISR_TAPS);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign sig_next[gi] = fb ^ din[0];
      end else if (gi < 3) begin : g_din
        assign sig_next[gi] = sig_reg[gi-1] ^ din[gi];
      end else begin : g_shift
        assign sig_next[gi] = sig_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig_reg <= 8'h00;
    end else if (en) begin
      sig_reg <= sig_next;
    end
  end

  assign sig = sig_reg;

endmodule

// File: rtl/odd_counter_checker.sv
// On-line checker for the odd up/down counter: predicts each next value,
// locks after SYNC_LEN good transitions, counts errors and signs the bus.
module odd_counter_checker
  import odd_cnt_pkg::*;
#(
  parameter int ERR_W    = 8,
  parameter int MAX_ERR  = 4,
  parameter int SYNC_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             p1,
  input  logic             p2,
  input  logic             p3,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             fail,
  output logic [7:0]       signature,
  output logic [1:0]       state
);

  localparam logic [ERR_W-1:0] MAX_ERR_W  = ERR_W'(MAX_ERR);
  localparam logic [2:0]       SYNC_LEN_W = 3'(SYNC_LEN);

  state_t           state_reg;
  logic [2:0]       sync_cnt_reg;
  logic [2:0]       v_q;
  logic             x_q;
  logic             hist_vld;
  logic [2:0]       v;
  logic [2:0]       exp_v;
  logic             mismatch;
  logic [2:0]       sync_inc;
  logic [ERR_W-1:0] err_inc;

  assign v        = {p3, p2, p1};
  assign exp_v    = next_odd(v_q, x_q);
  assign mismatch = (exp_v == 3'b000) || (v != exp_v);
  assign sync_inc = sync_cnt_reg + 3'd1;
  assign err_inc  = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_SYNC;
      sync_cnt_reg <= 3'd0;
      v_q          <= 3'd0;
      x_q          <= 1'b0;
      hist_vld     <= 1'b0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
      fail         <= 1'b0;
    end else if (!en) begin
      hist_vld  <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      v_q       <= v;
      x_q       <= x;
      hist_vld  <= 1'b1;
      err_pulse <= 1'b0;
      // A compare is only meaningful once the previous edge filled the history.
      case (state_reg)
        S_SYNC: begin
          if (hist_vld) begin
            if (mismatch) begin
              sync_cnt_reg <= 3'd0;
            end else if (sync_inc == SYNC_LEN_W) begin
              state_reg    <= S_LOCK;
              locked       <= 1'b1;
              sync_cnt_reg <= 3'd0;
            end else begin
              sync_cnt_reg <= sync_inc;
            end
          end
        end
        S_LOCK: begin
          if (hist_vld && mismatch) begin
            err_pulse <= 1'b1;
            err_count <= err_inc;
            if (err_inc >= MAX_ERR_W) begin
              state_reg <= S_FAIL;
              locked    <= 1'b0;
              fail      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Signature restarts from zero every time the checker is hunting for lock.
  odd_misr8 u_misr (
    .clk (clk),
    .rst (rst),
    .clr (state_reg == S_SYNC),
    .en  (en && (state_reg == S_LOCK)),
    .din (v),
    .sig (signature)
  );

  assign state = state_reg;

endmodule

// File: tb/tb_odd_counter_checker.sv
// Randomised self-checking bench for odd_counter_checker against a
// rule-level reference model of the checker.
module tb_odd_counter_checker;

  localparam int ERR_W    = 8;
  localparam int MAX_ERR  = 4;
  localparam int SYNC_LEN = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             x = 1'b0;
  logic             p1 = 1'b0;
  logic             p2 = 1'b0;
  logic             p3 = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             fail;
  logic [7:0]       signature;
  logic [1:0]       state;

  odd_counter_checker #(
    .ERR_W    (ERR_W),
    .MAX_ERR  (MAX_ERR),
    .SYNC_LEN (SYNC_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .x         (x),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .fail      (fail),
    .signature (signature),
    .state     (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  // reference model: 0=SYNC 1=LOCK 2=FAIL
  int       m_state = 0;
  int       m_sync  = 0;
  int       m_prev  = 0;
  int       m_xprev = 0;
  int       m_hist  = 0;
  int       m_cnt   = 0;
  int       m_pulse = 0;
  logic [7:0] m_sig = 8'h00;
  int       last_v  = 1;
  int       odd_seq[4] = '{1, 3, 5, 7};

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, ncyc, got, exp);
    end
  endtask

  // Position of an odd value in the 1,3,5,7 ring, -1 if not a legal value.
  function automatic int ring_pos(input int v);
    for (int i = 0; i < 4; i++) if (odd_seq[i] == v) return i;
    return -1;
  endfunction

  function automatic int legal_next(input int v, input int dir);
    int p;
    p = ring_pos(v);
    if (p < 0) return -1;
    return dir != 0 ? odd_seq[(p + 3) % 4] : odd_seq[(p + 1) % 4];
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] s, input int v);
    logic fb;
    logic [2:0] d;
    d  = 3'(v);
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb} ^ {5'b0, d};
  endfunction

  task automatic model(input int r, input int e, input int xi, input int vi);
    int ok;
    if (r != 0) begin
      m_state = 0; m_sync = 0; m_hist = 0; m_cnt = 0; m_pulse = 0; m_sig = 8'h00;
    end else if (e == 0) begin
      m_hist = 0; m_pulse = 0;
    end else begin
      ok = (legal_next(m_prev, m_xprev) == vi) ? 1 : 0;
      m_pulse = 0;
      if (m_state == 0) begin
        m_sig = 8'h00;
        if (m_hist != 0) begin
          if (ok != 0) begin
            m_sync++;
            if (m_sync == SYNC_LEN) begin m_state = 1; m_sync = 0; end
          end else m_sync = 0;
        end
      end else if (m_state == 1) begin
        m_sig = misr_step(m_sig, vi);
        if (m_hist != 0 && ok == 0) begin
          m_pulse = 1;
          if (m_cnt < (1 << ERR_W) - 1) m_cnt++;
          if (m_cnt >= MAX_ERR) m_state = 2;
        end
      end
      m_prev = vi; m_xprev = xi; m_hist = 1;
    end
  endtask

  task automatic step(input int r, input int e, input int xi, input int vi);
    logic [2:0] vb;
    vb = 3'(vi);
    rst = 1'(r); en = 1'(e); x = 1'(xi);
    {p3, p2, p1} = vb;
    @(posedge clk);
    model(r, e, xi, vi);
    last_v = vi;
    ncyc++;
    #1;
    $display("cyc=%0d rst=%0d en=%0d x=%0d v=%0d | st=%0d lk=%0d ep=%0d cnt=%0d fl=%0d sig=%02h",
             ncyc, r, e, xi, vi, state, locked, err_pulse, err_count, fail, signature);
    chk("state", int'(state), m_state);
    chk("locked", int'(locked), (m_state == 1) ? 1 : 0);
    chk("fail", int'(fail), (m_state == 2) ? 1 : 0);
    chk("err_pulse", int'(err_pulse), m_pulse);
    chk("err_count", int'(err_count), m_cnt);
    chk("signature", int'(signature), int'(m_sig));
  endtask

  task automatic relock();
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 3);
    step(0, 1, 0, 5);
  endtask

  initial begin
    int e, xi, vi, r, nx;
    // lock-up from reset with an up-count
    step(1, 1, 0, 3);
    step(1, 0, 0, 0);
    foreach (odd_seq[i]) step(0, 1, 0, odd_seq[i]);
    step(0, 1, 0, 1);
    step(0, 1, 0, 3);
    // direction change while v=5, wrap 1->7 on the way down
    step(0, 1, 1, 5);
    step(0, 1, 1, 3);
    step(0, 1, 1, 1);
    step(0, 1, 1, 7);
    step(0, 1, 1, 5);
    // two even values back to back
    relock();
    step(0, 1, 0, 4);
    step(0, 1, 0, 6);
    // error budget exhaustion, then frozen in FAIL
    relock();
    for (int i = 0; i < 9; i++) step(0, 1, 0, 2);
    // signature over 7,1,3 then en low with garbage
    relock();
    step(0, 1, 0, 7);
    step(0, 1, 0, 1);
    step(0, 1, 0, 3);
    for (int i = 0; i < 3; i++) step(0, 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    step(0, 1, 0, 5);
    step(0, 1, 0, 7);
    // reset mid-LOCK with two errors, then relock needs SYNC_LEN+1 edges
    relock();
    step(0, 1, 0, 0);
    step(0, 1, 0, 2);
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 3);
    step(0, 1, 0, 5);
    // mismatch on the edge that would complete SYNC
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 3);
    step(0, 1, 0, 3);
    step(0, 1, 0, 5);
    step(0, 1, 0, 7);
    // random traffic from a legal counter with occasional faults
    xi = 0;
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 99) == 0) ? 1 : 0;
      e  = ($urandom_range(0, 7) != 0) ? 1 : 0;
      if ($urandom_range(0, 5) == 0) xi = int'($urandom_range(0, 1));
      nx = legal_next(last_v, xi);
      if (nx < 0) nx = 1;
      vi = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : nx;
      step(r, e, xi, vi);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
